// File: rtl/fifo_sync_pkg.sv
// Purpose: shared defaults and pointer-wrap helper for the synchronous FIFO.
// Ports: none (package).
package fifo_sync_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_DEPTH = 4;

    // Advance a circular index; depth need not be a power of two.
    function automatic int unsigned next_idx(input int unsigned idx, input int unsigned depth);
        return (idx == depth - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/fifo_sync_if.sv
// Purpose: write/read handshake bundle of the synchronous FIFO.
// Ports (signals):
//   i_wr_dv/i_wr_data   producer write request and data
//   i_af_level          almost-full threshold
//   o_af_flag/o_full    fill-level flags
//   i_rd_en             consumer read request
//   i_ae_level          almost-empty threshold
//   o_ae_flag/o_empty   drain-level flags
//   o_rd_dv/o_rd_data   read data pulse and word
//   o_overflow/o_underflow  rejected-request pulses
// Modports: slave = FIFO side, master = producer/consumer side.
interface fifo_sync_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic             i_wr_dv;
    logic [WIDTH-1:0] i_wr_data;
    logic [CNT_W-1:0] i_af_level;
    logic             o_af_flag;
    logic             o_full;
    logic             i_rd_en;
    logic [CNT_W-1:0] i_ae_level;
    logic             o_ae_flag;
    logic             o_empty;
    logic             o_rd_dv;
    logic [WIDTH-1:0] o_rd_data;
    logic             o_overflow;
    logic             o_underflow;

    modport slave (
        input  i_wr_dv, i_wr_data, i_af_level, i_rd_en, i_ae_level,
        output o_af_flag, o_full, o_ae_flag, o_empty, o_rd_dv, o_rd_data,
               o_overflow, o_underflow
    );

    modport master (
        output i_wr_dv, i_wr_data, i_af_level, i_rd_en, i_ae_level,
        input  o_af_flag, o_full, o_ae_flag, o_empty, o_rd_dv, o_rd_data,
               o_overflow, o_underflow
    );

endinterface

// File: rtl/RAM_2Port.sv
// Purpose: simple dual-port RAM, one write port and one registered read port.
// Ports:
//   i_wr_clk, i_wr_addr, i_wr_dv, i_wr_data   write side
//   i_rd_clk, i_rd_rst_l                      read clock and output-register reset
//   i_rd_addr, i_rd_en                        read request
//   o_rd_dv, o_rd_data                        read result, one cycle after request
// The storage array itself is never reset.
module RAM_2Port #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     i_wr_clk,
    input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
    input  logic                     i_wr_dv,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic                     i_rd_clk,
    input  logic                     i_rd_rst_l,
    input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
    input  logic                     i_rd_en,
    output logic                     o_rd_dv,
    output logic [WIDTH-1:0]         o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Write port.
    always_ff @(posedge i_wr_clk) begin
        if (i_wr_dv) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Registered read port; data holds between reads.
    always_ff @(posedge i_rd_clk or negedge i_rd_rst_l) begin
        if (!i_rd_rst_l) begin
            o_rd_dv   <= 1'b0;
            o_rd_data <= '0;
        end else begin
            o_rd_dv <= i_rd_en;
            if (i_rd_en) begin
                o_rd_data <= r_mem[i_rd_addr];
            end
        end
    end

endmodule

// File: rtl/fifo_sync.sv
// Purpose: single-clock FIFO wrapping RAM_2Port with pointers, fill count,
//          full/empty/almost flags and overflow/underflow pulses.
// Ports:
//   i_clk    clock (both RAM ports)
//   i_rst_l  asynchronous active-low reset
//   bus      fifo_sync_if.slave: write/read handshake, thresholds, flags, data
module fifo_sync
    import fifo_sync_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input logic        i_clk,
    input logic        i_rst_l,
    fifo_sync_if.slave bus
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_full;
    logic             r_empty;
    logic             r_rd_acc;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_wr_acc;
    logic             w_rd_acc;
    logic [CNT_W-1:0] w_count_nxt;
    logic             w_ram_rd_dv;
    logic [WIDTH-1:0] w_ram_rd_data;

    // Acceptance uses the flags of the current cycle.
    assign w_wr_acc = bus.i_wr_dv & ~r_full;
    assign w_rd_acc = bus.i_rd_en & ~r_empty;

    // Next fill count.
    always_comb begin
        w_count_nxt = r_count;
        unique case ({w_wr_acc, w_rd_acc})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Pointers, count, full/empty and reject pulses.
    always_ff @(posedge i_clk or negedge i_rst_l) begin
        if (!i_rst_l) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_full      <= 1'b0;
            r_empty     <= 1'b1;
            r_rd_acc    <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= PTR_W'(next_idx(32'(r_wr_ptr), DEPTH));
            end
            if (w_rd_acc) begin
                r_rd_ptr <= PTR_W'(next_idx(32'(r_rd_ptr), DEPTH));
            end
            r_count     <= w_count_nxt;
            r_full      <= (w_count_nxt == CNT_W'(DEPTH));
            r_empty     <= (w_count_nxt == '0);
            r_rd_acc    <= w_rd_acc;
            r_overflow  <= bus.i_wr_dv & r_full;
            r_underflow <= bus.i_rd_en & r_empty;
        end
    end

    RAM_2Port #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .i_wr_clk   (i_clk),
        .i_wr_addr  (r_wr_ptr),
        .i_wr_dv    (w_wr_acc),
        .i_wr_data  (bus.i_wr_data),
        .i_rd_clk   (i_clk),
        .i_rd_rst_l (i_rst_l),
        .i_rd_addr  (r_rd_ptr),
        .i_rd_en    (w_rd_acc),
        .o_rd_dv    (w_ram_rd_dv),
        .o_rd_data  (w_ram_rd_data)
    );

    // Almost flags depend only on the count register and static thresholds.
    assign bus.o_af_flag   = (r_count >= bus.i_af_level);
    assign bus.o_ae_flag   = (r_count <= bus.i_ae_level);
    assign bus.o_full      = r_full;
    assign bus.o_empty     = r_empty;
    assign bus.o_rd_dv     = w_ram_rd_dv & r_rd_acc;
    assign bus.o_rd_data   = w_ram_rd_data;
    assign bus.o_overflow  = r_overflow;
    assign bus.o_underflow = r_underflow;

endmodule

// File: tb/tb_fifo_sync.sv
// Purpose: self-checking scoreboard bench for fifo_sync (WIDTH=8, DEPTH=4).
module tb_fifo_sync;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned AF    = 3;
    localparam int unsigned AE    = 1;

    logic clk;
    logic rst_n;

    fifo_sync_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    fifo_sync #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .i_clk   (clk),
        .i_rst_l (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_fail;

    logic [WIDTH-1:0] m_q[$];     // model FIFO contents
    logic [WIDTH-1:0] exp_q[$];   // expected read words, oldest first
    bit               rd_due;     // a read was accepted at the last edge
    logic [WIDTH-1:0] last_rd;    // expected held value of o_rd_data

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_flags(input string tag);
        int unsigned n;
        n = m_q.size();
        check({tag, "_full"},  32'(bus.o_full),    32'(n == DEPTH));
        check({tag, "_empty"}, 32'(bus.o_empty),   32'(n == 0));
        check({tag, "_af"},    32'(bus.o_af_flag), 32'(n >= AF));
        check({tag, "_ae"},    32'(bus.o_ae_flag), 32'(n <= AE));
    endtask

    // One clock of stimulus; the model decides acceptance from pre-edge state.
    task automatic step(input bit wr, input logic [WIDTH-1:0] d, input bit rd);
        bit wa;
        bit ra;
        wa = wr && (m_q.size() < DEPTH);
        ra = rd && (m_q.size() > 0);
        if (ra) exp_q.push_back(m_q.pop_front());
        if (wa) m_q.push_back(d);
        bus.i_wr_dv   = wr;
        bus.i_wr_data = d;
        bus.i_rd_en   = rd;
        @(posedge clk);
        #1;
        bus.i_wr_dv = 1'b0;
        bus.i_rd_en = 1'b0;
        rd_due = ra;
        check("ovf", 32'(bus.o_overflow),  32'(wr && !wa));
        check("unf", 32'(bus.o_underflow), 32'(rd && !ra));
        check_flags("st");
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_dv"},   32'(bus.o_rd_dv),     32'd0);
        check({tag, "_rd_data"}, 32'(bus.o_rd_data),   32'd0);
        check({tag, "_ovf"},     32'(bus.o_overflow),  32'd0);
        check({tag, "_unf"},     32'(bus.o_underflow), 32'd0);
        check_flags(tag);
    endtask

    // Output monitor: read data must arrive exactly one cycle after acceptance.
    always @(negedge clk) begin
        if (rst_n) begin
            check("rd_dv", 32'(bus.o_rd_dv), 32'(rd_due));
            if (rd_due && exp_q.size() != 0) last_rd = exp_q.pop_front();
            check("rd_data", 32'(bus.o_rd_data), 32'(last_rd));
            rd_due = 1'b0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rd_due   = 1'b0;
        last_rd  = '0;
        bus.i_wr_dv    = 1'b0;
        bus.i_wr_data  = '0;
        bus.i_rd_en    = 1'b0;
        bus.i_af_level = 3'(AF);
        bus.i_ae_level = 3'(AE);

        // Reset asserted mid-clock: outputs take reset values immediately.
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("rst");
        @(negedge clk);
        #1 rst_n = 1'b1;

        // Fill, then overflow.
        for (int i = 1; i <= 4; i++) step(1'b1, 8'(i), 1'b0);
        step(1'b1, 8'd5, 1'b0);

        // Drain, then underflow.
        for (int i = 0; i < 4; i++) step(1'b0, 8'd0, 1'b1);
        step(1'b0, 8'd0, 1'b1);

        // Interleaved writes/reads wrapping the pointers.
        for (int i = 10; i <= 12; i++) step(1'b1, 8'(i), 1'b0);
        for (int i = 13; i <= 15; i++) begin
            step(1'b1, 8'(i), 1'b1);
            step(1'b0, 8'd0, 1'b1);
        end
        while (m_q.size() > 0) step(1'b0, 8'd0, 1'b1);

        // Full with simultaneous write/read: read wins, write rejected.
        for (int i = 20; i <= 23; i++) step(1'b1, 8'(i), 1'b0);
        step(1'b1, 8'd99, 1'b1);
        while (m_q.size() > 0) step(1'b0, 8'd0, 1'b1);
        // Empty with simultaneous write/read: write wins, no fall-through.
        step(1'b1, 8'd84, 1'b1);
        step(1'b0, 8'd0, 1'b1);
        step(1'b0, 8'd0, 1'b0);

        // Reset while a read is in flight.
        step(1'b1, 8'd1, 1'b0);
        step(1'b1, 8'd2, 1'b0);
        bus.i_rd_en = 1'b1;
        @(posedge clk);
        #1 bus.i_rd_en = 1'b0;
        #1 rst_n = 1'b0;
        m_q.delete();
        exp_q.delete();
        rd_due  = 1'b0;
        last_rd = '0;
        #1 check_reset_outputs("mid_rst");
        @(negedge clk);
        #1 rst_n = 1'b1;
        step(1'b1, 8'd42, 1'b0);
        step(1'b0, 8'd0, 1'b1);
        step(1'b0, 8'd0, 1'b0);

        @(negedge clk);
        check("sb_left", 32'(exp_q.size()), 32'd0);
        check("model_left", 32'(m_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
